row_sequencer: RTL and testbench
================================

Name: row_sequencer

Overview:
Parametrised top-level sequencer for the row-by-row multiply datapath. On a start request it walks NUM_ROWS result rows. For each row it issues a begin_mult pulse with the row's result address, waits for the row engine's done_row, then advances. After the last row it raises a one-cycle completion strobe. It is the generalised successor of the fixed 10-row controller, adding:
- configurable row count and address width
- abort
- a busy indication
- a pulsed (not level) start to the row engine
- an optional per-row watchdog

Parameters:
NUM_ROWS, 10, number of rows per calculation; legal range 1..2^ADDR_W.
ADDR_W, 4, width of res_add.
TIMEOUT_CYCLES, 255, per-row watchdog limit in cycles; used only when ROW_SEQ_TIMEOUT_EN is defined.

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start_calc  in  1  request a new calculation; sampled only in IDLE
abort  in  1  cancel the calculation in progress
done_row  in  1  row engine finished the current row; honoured only in WAIT
res_add  out  ADDR_W  result row address for the current row
begin_mult  out  1  one-cycle pulse: start the row at res_add
busy  out  1  high in every state except IDLE
done_calc  out  1  one-cycle pulse: all rows complete (or watchdog error)
calc_err  out  1  one-cycle pulse coincident with done_calc on watchdog expiry

Behaviour:
- One clock domain; reset is synchronous and active-high. Ports are named clk and reset.
- Reset: state=IDLE, row counter=0, res_add=0, begin_mult=0, busy=0, done_calc=0, calc_err=0. Reset overrides all other inputs in the same cycle.
- Outputs are a Moore decode of the registered state and row counter. There is no combinational path from any input to any output.
- States and transitions:
  - IDLE: start_calc=1 and abort=0 -> SETUP; otherwise stay.
  - SETUP (1 cycle): row=0, res_add=0 -> ISSUE.
  - ISSUE (1 cycle): begin_mult=1, res_add=row -> WAIT. A done_row seen in ISSUE is ignored.
  - WAIT: res_add=row is held. On done_row=1, if row==NUM_ROWS-1 -> FLUSH; else row<=row+1 -> ISSUE.
  - FLUSH (1 cycle): res_add=0 -> WRITE_OUT.
  - WRITE_OUT (1 cycle): done_calc=1 -> IDLE.
  - ERR (1 cycle, only with the macro): done_calc=1, calc_err=1 -> IDLE.
- Abort:
  - In any non-IDLE state, abort=1 -> IDLE next cycle with row=0.
  - No done_calc is issued on abort. A begin_mult that would have issued that cycle is still decoded from the current state.
  - Abort has priority over done_row and the watchdog.
  - Abort together with start_calc in IDLE: stay IDLE.
- start_calc outside IDLE is ignored; it is not queued.
- Latency, with start_calc high in cycle 0:
  - SETUP in cycle 1; first begin_mult in cycle 2.
  - With done_row returned the cycle after each ISSUE, row k issues at cycle 2+2k.
  - done_calc at cycle 2*NUM_ROWS+3; IDLE (busy=0) at 2*NUM_ROWS+4.
- Row counter:
  - Width ADDR_W; never exceeds NUM_ROWS-1, so there is no wrap.
  - NUM_ROWS=1: a single ISSUE/WAIT, then FLUSH.
- done_row held high continuously: one row advances per ISSUE/WAIT pair, i.e. 2 cycles per row.
- busy=1 from SETUP through WRITE_OUT/ERR inclusive.

Optional Feature:
Macro ROW_SEQ_TIMEOUT_EN.
- Defined: a watchdog counter is cleared on entry to WAIT and increments each cycle in WAIT without done_row. When it reaches TIMEOUT_CYCLES, the next state is ERR (done_calc=1, calc_err=1 for one cycle), then IDLE. If done_row arrives in the same cycle the counter reaches its limit, done_row wins.
- Undefined: no counter is built, WAIT waits indefinitely, calc_err is tied to 0, and TIMEOUT_CYCLES is unused. The port list is identical in both builds.

Test Plan:
1. Reset asserted mid-WAIT on row 4 -> next cycle: all outputs 0, state IDLE; a following start_calc restarts from res_add=0.
2. NUM_ROWS=10; start_calc in cycle 0, done_row returned one cycle after each begin_mult -> begin_mult at cycles 2,4,...,20 with res_add 0..9; done_calc at cycle 23 only; busy low from cycle 24.
3. Variable done_row delay (0-5 extra cycles per row), plus done_row pulses injected during ISSUE -> exactly 10 begin_mult pulses; res_add stable through each WAIT; injected pulses cause no skipped row.
4. abort in cycle 9 (WAIT, row 3) -> IDLE in cycle 10; no done_calc; start_calc+abort together in IDLE -> stays IDLE.
5. NUM_ROWS=1, ADDR_W=1 -> one begin_mult at res_add=0; done_calc at cycle 5.
6. With ROW_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, done_row withheld on row 2 -> ERR after 8 WAIT cycles: done_calc=calc_err=1 for one cycle, then IDLE. Without the macro, the same stimulus holds WAIT and calc_err stays 0.

Source files
------------

// File: rtl/row_sequencer.sv
// Row-by-row multiply sequencer: walks NUM_ROWS rows, pulsing begin_mult per row and done_calc at the end.
// Optional per-row watchdog is built when ROW_SEQ_TIMEOUT_EN is defined.
module row_sequencer #(
    parameter int NUM_ROWS       = 10,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_calc,
    input  logic              abort,
    input  logic              done_row,
    output logic [ADDR_W-1:0] res_add,
    output logic              begin_mult,
    output logic              busy,
    output logic              done_calc,
    output logic              calc_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_WAIT,
        S_FLUSH,
        S_WRITE_OUT,
        S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] row_next;
    logic              wd_expired;

`ifdef ROW_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;

    // Cleared outside WAIT so every row starts its wait with a fresh budget.
    always_ff @(posedge clk) begin
        if (reset || state != S_WAIT) begin
            wd_cnt <= '0;
        end else if (!done_row) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    // No watchdog in this build: WAIT never expires.
    assign wd_expired = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            row   <= '0;
        end else begin
            state <= state_next;
            row   <= row_next;
        end
    end

    always_comb begin
        state_next = state;
        row_next   = row;
        if (abort && state != S_IDLE) begin
            state_next = S_IDLE;
            row_next   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    row_next = '0;
                    if (start_calc && !abort) state_next = S_SETUP;
                end
                S_SETUP: begin
                    row_next   = '0;
                    state_next = S_ISSUE;
                end
                S_ISSUE: state_next = S_WAIT;
                S_WAIT: begin
                    // done_row beats the watchdog when both land in the same cycle.
                    if (done_row) begin
                        if (row == LAST_ROW) begin
                            state_next = S_FLUSH;
                        end else begin
                            row_next   = row + 1'b1;
                            state_next = S_ISSUE;
                        end
                    end else if (wd_expired) begin
                        state_next = S_ERR;
                    end
                end
                S_FLUSH:     state_next = S_WRITE_OUT;
                S_WRITE_OUT: state_next = S_IDLE;
                S_ERR:       state_next = S_IDLE;
                default:     state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        res_add    = (state == S_ISSUE || state == S_WAIT) ? row : '0;
        begin_mult = (state == S_ISSUE);
        busy       = (state != S_IDLE);
        done_calc  = (state == S_WRITE_OUT || state == S_ERR);
`ifdef ROW_SEQ_TIMEOUT_EN
        calc_err   = (state == S_ERR);
`else
        calc_err   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_row_sequencer.sv
// Self-checking bench for row_sequencer: vector table, randomized row engine with a cycle-level model,
// single-row instance and watchdog scenario (behaviour depends on ROW_SEQ_TIMEOUT_EN).
module tb_row_sequencer;
    localparam int NR = 10;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset, start_calc, abort, done_row;
    logic [AW-1:0] res_add;
    logic          begin_mult, busy, done_calc, calc_err;

    logic          start1, abort1, done1;
    logic [0:0]    res_add1;
    logic          begin1, busy1, done_calc1, calc_err1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic          rst, start, abrt, done;
        logic [AW-1:0] e_res;
        logic          e_begin, e_busy, e_done;
    } vec_t;

    vec_t vecs[$];

    row_sequencer #(.NUM_ROWS(NR), .ADDR_W(AW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .start_calc(start_calc), .abort(abort), .done_row(done_row),
        .res_add(res_add), .begin_mult(begin_mult), .busy(busy), .done_calc(done_calc),
        .calc_err(calc_err)
    );

    row_sequencer #(.NUM_ROWS(1), .ADDR_W(1), .TIMEOUT_CYCLES(8)) dut1 (
        .clk(clk), .reset(reset), .start_calc(start1), .abort(abort1), .done_row(done1),
        .res_add(res_add1), .begin_mult(begin1), .busy(busy1), .done_calc(done_calc1),
        .calc_err(calc_err1)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Outputs are sampled and inputs driven on the falling edge.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic a, input logic d,
                       input int res, input logic b, input logic bu, input logic dn);
        vec_t v;
        v.rst = r; v.start = s; v.abrt = a; v.done = d;
        v.e_res = AW'(res); v.e_begin = b; v.e_busy = bu; v.e_done = dn;
        vecs.push_back(v);
    endtask

    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) begin
            step();
            chk($sformatf("vec%0d_res_add", i), res_add, vecs[i].e_res);
            chk($sformatf("vec%0d_begin_mult", i), begin_mult, vecs[i].e_begin);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("vec%0d_done_calc", i), done_calc, vecs[i].e_done);
            chk($sformatf("vec%0d_calc_err", i), calc_err, 0);
            reset      = vecs[i].rst;
            start_calc = vecs[i].start;
            abort      = vecs[i].abrt;
            done_row   = vecs[i].done;
        end
        reset = 0; start_calc = 0; abort = 0; done_row = 0;
    endtask

    // Random row engine: done_row after 0-5 extra cycles, plus random pulses during ISSUE.
    task automatic rand_calc();
        logic [AW-1:0] exp_q[$];
        logic [AW-1:0] cur_row;
        int next_issue, done_at, exp_done, rows_left, pulses;
        bit waiting, finished;
        for (int k = 0; k < NR; k++) exp_q.push_back(AW'(k));
        step();
        start_calc = 1; done_row = 0;
        next_issue = cyc + 2; done_at = -1; exp_done = -1;
        rows_left = NR; pulses = 0; waiting = 0; finished = 0; cur_row = '0;
        for (int n = 0; n < 300 && !finished; n++) begin
            step();
            start_calc = 0; done_row = 0;
            chk("rnd_busy", busy, 1);
            chk("rnd_begin", begin_mult, int'(cyc == next_issue));
            if (begin_mult) begin
                pulses++;
                if (exp_q.size() > 0) begin
                    cur_row = exp_q.pop_front();
                    chk("rnd_addr", res_add, cur_row);
                end
                done_at = cyc + 1 + int'($urandom_range(0, 5));
                waiting = 1;
                if ($urandom_range(0, 1) == 1) done_row = 1;
            end else if (waiting) begin
                chk("rnd_hold", res_add, cur_row);
                if (cyc == done_at) begin
                    done_row = 1;
                    waiting = 0;
                    rows_left--;
                    if (rows_left == 0) exp_done = cyc + 2;
                    else next_issue = cyc + 1;
                end
            end
            chk("rnd_done", done_calc, int'(cyc == exp_done));
            if (done_calc) finished = 1;
        end
        chk("rnd_finished", finished, 1);
        chk("rnd_pulses", pulses, NR);
        chk("rnd_queue_left", exp_q.size(), 0);
        step();
        chk("rnd_idle", busy, 0);
    endtask

    initial begin
        bit rows;
        int last_busy, err_cyc, wait_end;
        reset = 1; start_calc = 0; abort = 0; done_row = 0;
        start1 = 0; abort1 = 0; done1 = 0;
        repeat (3) step();
        chk("rst_res_add", res_add, 0);
        chk("rst_begin_mult", begin_mult, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_calc", done_calc, 0);
        chk("rst_calc_err", calc_err, 0);
        chk("rst1_busy", busy1, 0);
        reset = 0;

        // Full 10-row run, done_row one cycle after each begin_mult.
        for (int c = 0; c < 26; c++) begin
            rows = (c >= 2 && c <= 21);
            add(0, c == 0, 0, (c % 2 == 1) && c >= 3 && c <= 21, rows ? (c - 2) / 2 : 0,
                rows && (c % 2 == 0), c >= 1 && c <= 23, c == 23);
        end
        // Abort in WAIT of row 3 (with done_row), then start+abort together in IDLE.
        for (int c = 0; c < 15; c++) begin
            rows = (c >= 2 && c <= 9);
            add(0, c == 0 || c == 10, c == 9 || c == 10, (c % 2 == 1) && c >= 3 && c <= 9,
                rows ? (c - 2) / 2 : 0, rows && (c % 2 == 0), c >= 1 && c <= 9, 0);
        end
        // Reset in WAIT of row 4, restart from row 0, abort to clean up.
        for (int c = 0; c < 17; c++) begin
            rows = (c >= 2 && c <= 11);
            add(c == 11, c == 0 || c == 12, c == 15, (c % 2 == 1) && c >= 3 && c <= 11,
                rows ? (c - 2) / 2 : 0, (rows && (c % 2 == 0)) || c == 14,
                (c >= 1 && c <= 11) || (c >= 13 && c <= 15), 0);
        end
        run_table();

        // Single-row instance.
        for (int c = 0; c < 8; c++) begin
            step();
            chk("one_begin", begin1, int'(c == 2));
            chk("one_res_add", res_add1, 0);
            chk("one_busy", busy1, int'(c >= 1 && c <= 5));
            chk("one_done", done_calc1, int'(c == 5));
            chk("one_err", calc_err1, 0);
            start1 = (c == 0);
            done1  = (c == 3);
        end
        start1 = 0; done1 = 0;

        repeat (3) rand_calc();

        // Row 2 never answered.
`ifdef ROW_SEQ_TIMEOUT_EN
        last_busy = 15; err_cyc = 15; wait_end = 14;
`else
        last_busy = 20; err_cyc = -1; wait_end = 20;
`endif
        for (int c = 0; c < 22; c++) begin
            step();
            chk("wd_busy", busy, int'(c >= 1 && c <= last_busy));
            chk("wd_done", done_calc, int'(c == err_cyc));
            chk("wd_err", calc_err, int'(c == err_cyc));
            chk("wd_begin", begin_mult, int'(c == 2 || c == 4 || c == 6));
            chk("wd_res_add", res_add, (c == 4 || c == 5) ? 1 : (c >= 6 && c <= wait_end) ? 2 : 0);
            start_calc = (c == 0);
            done_row   = (c == 3 || c == 5);
            abort      = (c == 20);
        end
        start_calc = 0; done_row = 0; abort = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
